// File: rtl/cam_pkg.sv
// Shared definitions for the camera readout capture block: state encoding,
// default geometry and row placement within an assembled frame.
package cam_pkg;

  localparam int ADC_W_DEF = 8;
  localparam int NCOL_DEF  = 2;

  localparam logic [1:0] ST_WAIT_EXP = 2'b00;
  localparam logic [1:0] ST_EXPOSE   = 2'b01;
  localparam logic [1:0] ST_READ     = 2'b10;
  localparam logic [1:0] ST_DONE     = 2'b11;

  // Row slot index inside frame_data (row 1 low half, row 2 high half).
  localparam int ROW1 = 0;
  localparam int ROW2 = 1;

endpackage

// File: rtl/readout_capture_edge_det.sv
// Single-bit rising/falling edge detector; the delayed copy is the only state.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  // Delay the input by one clock for edge comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/readout_capture.sv
// Captures two ADC rows strobed by the exposure controller into one frame,
// hands it downstream over valid/ready and flags handshake protocol errors.
module readout_capture
  import cam_pkg::*;
#(
  parameter int ADC_W = ADC_W_DEF,
  parameter int NCOL  = NCOL_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      expose,
  input  logic                      erase,
  input  logic                      NRE_1,
  input  logic                      NRE_2,
  input  logic                      ADC,
  input  logic [ADC_W*NCOL-1:0]     adc_data,
  input  logic                      frame_ready,
  input  logic                      err_clr,
  output logic                      frame_valid,
  output logic [2*NCOL*ADC_W-1:0]   frame_data,
  output logic                      proto_err,
  output logic                      overrun
);

  localparam int RW = ADC_W * NCOL;

  logic          adc_rise_s;
  logic          adc_fall_unused;
  logic          exp_rise_s;
  logic          exp_fall_s;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] row1_q, row1_d;
  logic [RW-1:0] row2_q, row2_d;
  logic          got1_q, got1_d;
  logic          got2_q, got2_d;
  logic          frame_valid_q, frame_valid_d;
  logic [2*RW-1:0] frame_data_q, frame_data_d;
  logic          proto_err_q, proto_err_d;
  logic          overrun_q, overrun_d;
  logic          err_set_s;
  logic          ovr_set_s;

  edge_det u_adc_edge (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (ADC),
    .rise_o (adc_rise_s),
    .fall_o (adc_fall_unused)
  );

  edge_det u_exp_edge (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (expose),
    .rise_o (exp_rise_s),
    .fall_o (exp_fall_s)
  );

  // Readout sequencing, row capture and frame hand-off.
  always_comb begin
    state_d       = state_q;
    row1_d        = row1_q;
    row2_d        = row2_q;
    got1_d        = got1_q;
    got2_d        = got2_q;
    frame_valid_d = frame_valid_q;
    frame_data_d  = frame_data_q;
    err_set_s     = 1'b0;
    ovr_set_s     = 1'b0;
    case (state_q)
      ST_WAIT_EXP: begin
        if (exp_rise_s) begin
          state_d = ST_EXPOSE;
          got1_d  = 1'b0;
          got2_d  = 1'b0;
        end else begin
          state_d = ST_WAIT_EXP;
        end
      end
      ST_EXPOSE: begin
        if (adc_rise_s) begin
          err_set_s = 1'b1;
        end else begin
          err_set_s = 1'b0;
        end
        if (exp_fall_s) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_EXPOSE;
        end
      end
      ST_READ: begin
        if (got1_q && got2_q) begin
          state_d       = ST_DONE;
          frame_valid_d = 1'b1;
          frame_data_d[ROW1*RW +: RW] = row1_q;
          frame_data_d[ROW2*RW +: RW] = row2_q;
        end else if (erase) begin
          state_d   = ST_WAIT_EXP;
          err_set_s = 1'b1;
        end else if (adc_rise_s) begin
          // Exactly one NRE line must be low; a repeated row is kept but flagged.
          if (!NRE_1 && NRE_2) begin
            row1_d    = adc_data;
            got1_d    = 1'b1;
            err_set_s = got1_q;
          end else if (!NRE_2 && NRE_1) begin
            row2_d    = adc_data;
            got2_d    = 1'b1;
            err_set_s = got2_q;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DONE: begin
        if (frame_valid_q && frame_ready) begin
          frame_valid_d = 1'b0;
          if (exp_rise_s) begin
            state_d = ST_EXPOSE;
            got1_d  = 1'b0;
            got2_d  = 1'b0;
          end else begin
            state_d = ST_WAIT_EXP;
          end
        end else if (exp_rise_s) begin
          ovr_set_s = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_WAIT_EXP;
      end
    endcase
  end

  // Sticky error flags: a new error in the same cycle overrides the clear.
  always_comb begin
    if (err_set_s) begin
      proto_err_d = 1'b1;
    end else if (err_clr) begin
      proto_err_d = 1'b0;
    end else begin
      proto_err_d = proto_err_q;
    end
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_WAIT_EXP;
      row1_q        <= {RW{1'b0}};
      row2_q        <= {RW{1'b0}};
      got1_q        <= 1'b0;
      got2_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= {(2*RW){1'b0}};
      proto_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      row1_q        <= row1_d;
      row2_q        <= row2_d;
      got1_q        <= got1_d;
      got2_q        <= got2_d;
      frame_valid_q <= frame_valid_d;
      frame_data_q  <= frame_data_d;
      proto_err_q   <= proto_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign proto_err   = proto_err_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/readout_capture.md
Name: readout_capture

Overview:
- Receiving end of the camera control handshake: watches `expose`, `erase`, `NRE_1`, `NRE_2` and `ADC` strobes from the exposure controller.
- On each `ADC` strobe it latches the shared column ADC bus into the row selected by the active-low NRE line.
- It assembles a 2-row x NCOL frame and offers it downstream with a valid/ready handshake.
- It flags protocol violations: bad strobe qualifiers, aborted readout, frame overrun.

Parameters:
- ADC_W, 8, bits per pixel sample.
- NCOL, 2, columns per row; the ADC bus carries one sample per column.

Ports:
- clk  in  1  system clock; all inputs synchronous to it.
- reset  in  1  asynchronous, active-low reset.
- expose  in  1  exposure phase active (from controller).
- erase  in  1  pixel erase/reset active (from controller).
- NRE_1  in  1  row 1 read enable, active-low.
- NRE_2  in  1  row 2 read enable, active-low.
- ADC  in  1  conversion strobe; sample taken on its rising edge.
- adc_data  in  ADC_W*NCOL  column ADC results; column c at bits [c*ADC_W +: ADC_W].
- frame_ready  in  1  downstream accepts frame.
- err_clr  in  1  clears sticky error flags.
- frame_valid  out  1  frame_data holds a complete frame.
- frame_data  out  2*NCOL*ADC_W  row 1 in the low half, row 2 in the high half; same column order as adc_data.
- proto_err  out  1  sticky protocol-violation flag.
- overrun  out  1  sticky flag: a new exposure started while a frame was still unread.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=WAIT_EXP; frame_valid=0; frame_data=0; proto_err=0; overrun=0.
  - row-captured bits = 0; ADC/expose edge registers = 0.
- Edge detection:
  - adc_rise = ADC & ~adc_q; exp_rise = expose & ~exp_q; exp_fall = ~expose & exp_q.
  - adc_q and exp_q are registered every cycle.
- States:
  - WAIT_EXP: exp_rise -> EXPOSE, clears row-captured bits.
  - EXPOSE: exp_fall -> READ. adc_rise here sets proto_err; the sample is ignored.
  - READ, on adc_rise, by qualifier:
    - NRE_1=0, NRE_2=1: latch adc_data into the row 1 register and set got1.
    - NRE_2=0, NRE_1=1: latch adc_data into the row 2 register and set got2.
    - Both low or both high: proto_err=1, sample discarded.
    - Re-capture of an already captured row: data overwritten, proto_err=1.
  - READ, erase=1 while not (got1 & got2): abort to WAIT_EXP, proto_err=1, frame_valid stays 0.
  - READ -> DONE on the clock after the second distinct row is captured. frame_valid=1 from that cycle; frame_data updated on that same cycle.
  - DONE:
    - frame_valid & frame_ready -> WAIT_EXP, frame_valid=0 next cycle.
    - frame_data holds its value until the next frame completes.
- Latency: the edge where ADC is first seen high latches the data. frame_valid rises exactly 1 clock after the second row's latch edge.
- Overrun:
  - exp_rise while in DONE sets overrun. The frame is held and the new exposure is dropped.
  - After the handshake the block returns to WAIT_EXP and waits for the next exp_rise.
- Simultaneous events:
  - If exp_rise and frame_ready arrive together in DONE: the handshake completes, overrun is not set, and the state goes to EXPOSE directly.
  - If err_clr coincides with a new error, the error wins (flag stays 1).
- Handshake rules:
  - frame_valid is never deasserted without frame_ready.
  - frame_data is stable while frame_valid=1.
- Idle-state strobes: erase, NRE_x and ADC activity in WAIT_EXP is ignored.

Decomposition:
- Shared package (cam_pkg), holding:
  - State encoding: WAIT_EXP=2'b00, EXPOSE=2'b01, READ=2'b10, DONE=2'b11.
  - Default ADC_W and NCOL.
  - Row index constants.
- One natural sub-module: `edge_det` (1-bit rising/falling edge detector with async active-low reset), instantiated for ADC and expose.

Test Plan:
1. Nominal frame:
   - Stimulus: expose pulse; NRE_1=0 with ADC pulse while adc_data=16'hA1B2; NRE_2=0 with ADC pulse while adc_data=16'hC3D4; frame_ready=1.
   - Response: frame_valid=1 one clock after the second latch; frame_data=32'hC3D4A1B2; frame_valid=0 after the handshake.
2. Backpressure:
   - Stimulus: nominal frame with frame_ready=0 for 10 cycles.
   - Response: frame_valid and frame_data stable for all 10 cycles; cleared after ready.
3. Bad qualifier:
   - Stimulus: ADC pulse in READ with NRE_1=NRE_2=0.
   - Response: proto_err=1, neither row register changes; err_clr -> proto_err=0.
4. Abort:
   - Stimulus: erase=1 after only row 1 is captured.
   - Response: state back to WAIT_EXP, proto_err=1, frame_valid never asserted.
5. Overrun:
   - Stimulus: second expose rise while DONE with frame_ready=0.
   - Response: overrun=1, frame_data unchanged; simultaneous ready+exp_rise -> no overrun, state enters EXPOSE.
6. Reset mid-readout:
   - Stimulus: reset=0 asynchronously between the row 1 and row 2 captures.
   - Response: all outputs 0 immediately, without waiting for clk; the next full frame captures correctly.
